// File: rtl/if_fetch_buffer.sv
// Instruction-fetch stage: owns the PC, samples the combinational instruction
// port and queues fetched words in a 2-entry skid FIFO toward decode.
module if_fetch_buffer #(
  parameter logic [31:0] RESET_PC          = 32'h0000_0000,
  parameter int unsigned INST_REGION_BYTES = 1024,
  parameter logic [31:0] NOP_INST          = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_addr_o,
  input  logic [31:0] inst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        if_valid_o,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc_o,
  output logic        if_fault_o
);

  localparam int unsigned W = 32;

  typedef enum logic {FETCH = 1'b0, HALT = 1'b1} state_t;

  typedef struct packed {
    logic [W-1:0] pc;
    logic [W-1:0] inst;
    logic         fault;
  } entry_t;

  state_t       state;
  logic [W-1:0] pc;
  logic [1:0]   count;
  logic         valid_q;
  entry_t       head;
  entry_t       tail;

  logic         pop;
  logic         push;
  logic         fault_c;
  entry_t       new_entry;

  // Handshake and fault qualification for the word at the current pc
  always_comb begin
    pop     = valid_q & id_ready_i;
    push    = (state == FETCH) & ~redirect_i & ((count < 2'd2) | pop);
    fault_c = (pc[1:0] != 2'b00) | (pc >= W'(INST_REGION_BYTES));
    new_entry.pc    = pc;
    new_entry.inst  = fault_c ? NOP_INST : inst_i;
    new_entry.fault = fault_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      count   <= 2'd0;
      valid_q <= 1'b0;
      head    <= '0;
      tail    <= '0;
    end else if (redirect_i) begin
      // Flush wins over any same-cycle pop or push
      state   <= FETCH;
      pc      <= redirect_pc_i;
      count   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      if (push) begin
        if (fault_c) begin
          state <= HALT;
        end else begin
          pc <= pc + W'(4);
        end
      end
      case (count)
        2'd0: begin
          if (push) begin
            head    <= new_entry;
            count   <= 2'd1;
            valid_q <= 1'b1;
          end
        end
        2'd1: begin
          if (pop && push) begin
            head <= new_entry;
          end else if (pop) begin
            count   <= 2'd0;
            valid_q <= 1'b0;
          end else if (push) begin
            tail  <= new_entry;
            count <= 2'd2;
          end
        end
        default: begin
          // Full: a push is only possible alongside a pop
          if (pop) begin
            head <= tail;
            if (push) begin
              tail <= new_entry;
            end else begin
              count <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign pc_addr_o  = pc;
  assign if_valid_o = valid_q;
  assign if_inst_o  = head.inst;
  assign if_pc_o    = head.pc;
  assign if_fault_o = head.fault;

endmodule
